// File: rtl/control_module_pkg.sv
// rtl/control_module_pkg.sv - shared state encoding and derived frame constants
package control_module_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_FLUSH = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  function automatic int calc_n(input int img_w, input int img_h);
    return img_w * img_h;
  endfunction

  // Pixels that must land in the row buffer before the first window read.
  function automatic int calc_lag(input int img_w, input int k);
    return (k - 1) * img_w;
  endfunction

  function automatic int calc_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/control_module_if.sv
// rtl/control_module_if.sv - frame request and pipeline enable bundle
interface control_module_if;
  logic start;
  logic complete;
  logic en_e_mem_addr;
  logic en_w_bram_addr;
  logic en_r_bram_addr;
  logic en_a;
  logic en_b;

  modport master (
    input  start,
    output complete, en_e_mem_addr, en_w_bram_addr, en_r_bram_addr, en_a, en_b
  );

  modport slave (
    output start,
    input  complete, en_e_mem_addr, en_w_bram_addr, en_r_bram_addr, en_a, en_b
  );
endinterface

// File: rtl/control_module_en_delay_line.sv
// rtl/control_module_en_delay_line.sv - registered enable delay of DEPTH cycles
module en_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];
endmodule

// File: rtl/control_module.sv
// rtl/control_module.sv - frame sequencer for a row-buffered KxK window pipeline
module control_module
  import control_module_pkg::*;
#(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int K     = 3
) (
  input logic            clk,
  input logic            rst_n,
  control_module_if.master bus
);
  localparam int N   = calc_n(IMG_W, IMG_H);
  localparam int LAG = calc_lag(IMG_W, K);
  localparam int CW  = calc_cnt_w(N);

  localparam logic [CW-1:0] N_C   = CW'(N);
  localparam logic [CW:0]   LAG_C = (CW+1)'(LAG);

  state_t          state;
  logic [CW-1:0]   pix_cnt;
  logic [CW-1:0]   wr_cnt;
  logic            en_e;
  logic            en_r;
  logic            complete;
  logic            en_w;
  logic            en_a;
  logic            en_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pix_cnt  <= '0;
      en_e     <= 1'b0;
      complete <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state   <= ST_RUN;
            en_e    <= 1'b1;
            pix_cnt <= CW'(1);
          end
        end
        ST_RUN: begin
          if (pix_cnt == N_C) begin
            en_e  <= 1'b0;
            state <= ST_FLUSH;
          end else begin
            pix_cnt <= pix_cnt + CW'(1);
          end
        end
        ST_FLUSH: begin
          // Only the final en_b pulse remains once every earlier stage has drained.
          if (en_b && !en_a && !en_r && !en_w) begin
            state    <= ST_DONE;
            complete <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!bus.start) begin
            state    <= ST_IDLE;
            complete <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // en_r is registered one cycle ahead: next cycle's write count is wr_cnt plus this cycle's write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt <= '0;
      en_r   <= 1'b0;
    end else begin
      if (state == ST_IDLE) wr_cnt <= '0;
      else if (en_w)        wr_cnt <= wr_cnt + CW'(1);
      en_r <= en_e && (({1'b0, wr_cnt} + {{CW{1'b0}}, en_w}) >= LAG_C);
    end
  end

  en_delay_line #(.DEPTH(1)) u_dly_w (.clk(clk), .rst_n(rst_n), .d(en_e), .q(en_w));
  en_delay_line #(.DEPTH(1)) u_dly_a (.clk(clk), .rst_n(rst_n), .d(en_r), .q(en_a));
  en_delay_line #(.DEPTH(1)) u_dly_b (.clk(clk), .rst_n(rst_n), .d(en_a), .q(en_b));

  assign bus.complete       = complete;
  assign bus.en_e_mem_addr  = en_e;
  assign bus.en_w_bram_addr = en_w;
  assign bus.en_r_bram_addr = en_r;
  assign bus.en_a           = en_a;
  assign bus.en_b           = en_b;
endmodule

// File: tb/tb_control_module.sv
// tb/tb_control_module.sv - randomized frame timing check against a cycle-window model
module tb_control_module;
  localparam int W0 = 8, H0 = 4, K0 = 3;
  localparam int W1 = 4, H1 = 2, K1 = 2;
  localparam int HOLD = 100000;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  control_module_if if0();
  control_module_if if1();

  control_module #(.IMG_W(W0), .IMG_H(H0), .K(K0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  control_module #(.IMG_W(W1), .IMG_H(H1), .K(K1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int n_of(input int d);
    return (d == 0) ? W0 * H0 : W1 * H1;
  endfunction

  function automatic int lag_of(input int d);
    return (d == 0) ? (K0 - 1) * W0 : (K1 - 1) * W1;
  endfunction

  // {complete, en_b, en_a, en_r, en_w, en_e}
  function automatic logic [5:0] obs(input int d);
    if (d == 0)
      return {if0.complete, if0.en_b, if0.en_a, if0.en_r_bram_addr, if0.en_w_bram_addr, if0.en_e_mem_addr};
    return {if1.complete, if1.en_b, if1.en_a, if1.en_r_bram_addr, if1.en_w_bram_addr, if1.en_e_mem_addr};
  endfunction

  task automatic set_start(input int d, input logic v);
    if (d == 0) if0.start = v;
    else        if1.start = v;
  endtask

  // Expected outputs in cycle c of a frame whose start is last seen high in cycle s-1.
  function automatic logic [5:0] expv(input int d, input int c, input int s);
    int n, lag, c_end;
    n     = n_of(d);
    lag   = lag_of(d);
    c_end = (s > n + 3) ? s : n + 3;
    return {(c >= n + 3) && (c <= c_end),
            (c >= lag + 3) && (c <= n + 2),
            (c >= lag + 2) && (c <= n + 1),
            (c >= lag + 1) && (c <= n),
            (c >= 1) && (c <= n),
            (c < n)};
  endfunction

  task automatic run_frame(input int d, input int s);
    int n, lag, win, cnt_e, cnt_r, cnt_b;
    logic [5:0] o;
    n = n_of(d); lag = lag_of(d); win = n + 12;
    cnt_e = 0; cnt_r = 0; cnt_b = 0;
    set_start(d, 1'b1);
    for (int c = 0; c < win; c++) begin
      @(negedge clk);
      o = obs(d);
      check_eq($sformatf("d%0d s%0d cyc%0d", d, s, c), 32'(o), 32'(expv(d, c, s)));
      cnt_e += int'(o[0]);
      cnt_r += int'(o[2]);
      cnt_b += int'(o[4]);
      set_start(d, c < s);
    end
    check_eq($sformatf("d%0d cnt_e", d), cnt_e, n);
    check_eq($sformatf("d%0d cnt_r", d), cnt_r, n - lag);
    check_eq($sformatf("d%0d cnt_b", d), cnt_b, n - lag);
    set_start(d, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [5:0] o;
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0;
    if0.start = 1'b0;
    if1.start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset d0", 32'(obs(0)), 0);
    check_eq("reset d1", 32'(obs(1)), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("idle d0", 32'(obs(0)), 0);
    check_eq("idle d1", 32'(obs(1)), 0);

    run_frame(0, HOLD);
    run_frame(1, HOLD);
    run_frame(0, 0);
    run_frame(1, 0);
    for (int i = 0; i < 8; i++) begin
      int d, s;
      d = i % 2;
      s = int'($urandom_range(n_of(d) + 8, 0));
      run_frame(d, s);
    end

    // Reset in the middle of a frame, then a full restart with start held.
    if0.start = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      o = obs(0);
      check_eq($sformatf("pre-rst cyc%0d", c), 32'(o), 32'(expv(0, c, HOLD)));
    end
    rst_n = 1'b0;
    #1;
    check_eq("mid-rst d0", 32'(obs(0)), 0);
    check_eq("mid-rst d1", 32'(obs(1)), 0);
    @(negedge clk);
    check_eq("rst-held d0", 32'(obs(0)), 0);
    rst_n = 1'b1;
    run_frame(0, HOLD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/control_module.md
CONTROL_MODULE -- requirements
Module: control_module

Interface
REQ-001 Parameter IMG_W, 256, image width in pixels (>=2).
REQ-002 Parameter IMG_H, 256, image height in rows (>=K).
REQ-003 Parameter K, 3, window size (2..IMG_H); the row buffer holds K-1 rows.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  level request to process one frame.
REQ-007 complete  output  1  frame finished; held high until start drops.
REQ-008 en_e_mem_addr  output  1  advance external-memory read address (one pixel fetched).
REQ-009 en_w_bram_addr  output  1  BRAM row-buffer write enable and write-address advance.
REQ-010 en_r_bram_addr  output  1  BRAM row-buffer read-address advance.
REQ-011 en_a  output  1  load enable, window register stage A.
REQ-012 en_b  output  1  load enable, window register stage B.

Function
REQ-013 Definitions: N = IMG_W*IMG_H; LAG = (K-1)*IMG_W; cycle 0 = clock period after the edge at which IDLE samples start=1.
REQ-014 FSM states IDLE, RUN, FLUSH, DONE; IDLE->RUN on start=1; RUN->FLUSH after N fetches; FLUSH->DONE after last en_b; DONE->IDLE when start=0.
REQ-015 All outputs are registered (no combinational path from start).
REQ-016 en_e_mem_addr high exactly in cycles 0..N-1, one pulse per pixel, no gaps.
REQ-017 en_w_bram_addr equals en_e_mem_addr delayed one cycle (memory read latency 1): cycles 1..N.
REQ-018 en_r_bram_addr high in every cycle where en_w_bram_addr is high and at least LAG writes have already completed: cycles LAG+1..N, count N-LAG.
REQ-019 en_a equals en_r_bram_addr delayed one cycle (BRAM read latency 1); en_b equals en_a delayed one cycle.
REQ-020 complete rises at cycle N+3 (first cycle after last en_b) and stays high in DONE.
REQ-021 start is ignored outside IDLE and DONE; deasserting start mid-frame does not abort.
REQ-022 start held high continuously yields exactly one frame; a new frame requires start low then high.
REQ-023 Pixel and write counters are $clog2(N+1) bits wide and never wrap within a frame.

Reset
REQ-024 rst_n=0 asynchronously forces state IDLE, clears all counters and delay registers, and drives every output to 0.
REQ-025 Reset asserted mid-frame aborts the frame; after release the block waits in IDLE for start.

Structure
REQ-026 Shared package holds the state enum and the derived constants N, LAG and counter width.
REQ-027 One sub-module, en_delay_line (parameterised depth-1 registered enable delay, async active-low reset), instanced for w, r->a, a->b stages.

Verification
REQ-028 IMG_W=8, IMG_H=4, K=3, start=1 held -> en_e cycles 0-31, en_w 1-32, en_r 17-32, en_a 18-33, en_b 19-34, complete high from 35.
REQ-029 Same config, count pulses -> en_e=32, en_w=32, en_r=16, en_a=16, en_b=16; start kept high -> no second frame.
REQ-030 Defaults, start=1 held -> en_r count 65024, complete rises at cycle 65539.
REQ-031 rst_n low at cycle 10 of a frame -> all outputs 0 immediately; after release with start=1 a full frame restarts from cycle 0.
REQ-032 start pulsed high one cycle then low -> full frame runs; complete rises then falls one cycle later (DONE sees start=0).
REQ-033 IMG_W=4, IMG_H=2, K=2 -> en_r cycles 5-8 (LAG=4), complete at cycle 11.
